// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the EX/MEM stage and a word-only data memory.
// It turns byte-addressed RV32 loads and stores into word-indexed memory accesses:
//   - SB/SH become a read-modify-write.
//   - Loads get lane select plus sign/zero extension.
//   - Misaligned, out-of-range or bad-funct3 requests are answered with an error and never
//     touch memory.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_we/req_funct3         store flag and RV32 funct3
//   req_addr/req_wdata        byte address and store data
//   resp_valid/rdata/err      one-cycle completion pulse, extended load data, error flag
//   mem_addr/wdata            word index and write word
//   mem_lw_en/sw_en           memory read/write enables
//   mem_rdata                 memory read word
module lsu_align #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_lw_en,
  output logic        mem_sw_en,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned LatW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e              state_q;
  logic                we_q;
  logic [2:0]          funct3_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [LatW-1:0]     cnt_q;

  logic        dec_err;
  logic [31:0] req_idx;
  logic [31:0] lat_idx;
  logic [31:0] load_data;
  logic [31:0] merge_word;

  assign req_ready = (state_q == StIdle) & ~rst;
  assign req_idx   = 32'(req_addr[ADDR_W+1:2]);
  assign lat_idx   = 32'(addr_q[ADDR_W+1:2]);

  // Request decode; funct3[1:0] is the access size for both loads and stores.
  always_comb begin
    logic f3_ok;
    logic mis;
    logic oor;
    if (req_we) f3_ok = (req_funct3 == 3'b000) | (req_funct3 == 3'b001) | (req_funct3 == 3'b010);
    else        f3_ok = (req_funct3 != 3'b011) & (req_funct3 != 3'b110) & (req_funct3 != 3'b111);
    mis = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
          ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    oor = (req_addr >> (ADDR_W + 2)) != 32'd0;
    dec_err = ~f3_ok | mis | oor;
  end

  // Lane select and extension of the word returned by memory.
  always_comb begin
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    case (addr_q[1:0])
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'd0, rd_byte};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = mem_rdata;
    endcase
  end

  // Store word: captured word with the addressed lane replaced (SW uses wdata as-is).
  always_comb begin
    merge_word = mem_rdata;
    case (funct3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'd0:    merge_word[7:0]   = wdata_q[7:0];
          2'd1:    merge_word[15:8]  = wdata_q[7:0];
          2'd2:    merge_word[23:16] = wdata_q[7:0];
          default: merge_word[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merge_word[31:16] = wdata_q[15:0];
        else           merge_word[15:0]  = wdata_q[15:0];
      end
      default: merge_word = wdata_q;
    endcase
  end

  // All outputs are registered and default to zero each cycle; each state re-asserts
  // what the following cycle needs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      cnt_q      <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_lw_en  <= 1'b0;
      mem_sw_en  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_lw_en  <= 1'b0;
      mem_sw_en  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[ADDR_W+1:0];
            wdata_q  <= req_wdata;
            cnt_q    <= '0;
            if (dec_err) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (req_we && req_funct3[1:0] == 2'b10) begin
              state_q   <= StWr;
              mem_sw_en <= 1'b1;
              mem_addr  <= req_idx;
              mem_wdata <= req_wdata;
            end else begin
              state_q   <= StRd;
              mem_lw_en <= 1'b1;
              mem_addr  <= req_idx;
            end
          end
        end
        StRd: begin
          if (cnt_q == LatW'(MEM_LAT - 1)) begin
            if (we_q) begin
              state_q   <= StWr;
              mem_sw_en <= 1'b1;
              mem_addr  <= lat_idx;
              mem_wdata <= merge_word;
            end else begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_rdata <= load_data;
            end
          end else begin
            cnt_q     <= cnt_q + 1'b1;
            mem_lw_en <= 1'b1;
            mem_addr  <= lat_idx;
          end
        end
        StWr: begin
          state_q    <= StResp;
          resp_valid <= 1'b1;
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;

  typedef struct {
    bit          use3;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          lw;
    int          sw;
    logic [31:0] mwdata;
    logic [31:0] maddr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rv = 1'b0;
  logic use3 = 1'b0;
  logic we = 1'b0;
  logic [2:0] f3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  logic rdy1, rv1, resp1, err1, lw1, sw1;
  logic [31:0] rdata1, maddr1, mwdata1, mrdata1;
  logic rdy3, rv3, resp3, err3, lw3, sw3;
  logic [31:0] rdata3, maddr3, mwdata3, mrdata3;
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];

  int n_checks = 0;
  int n_fail = 0;
  vec_t vecs [21];

  always #5 clk = ~clk;

  assign rv1 = rv & ~use3;
  assign rv3 = rv & use3;
  assign mrdata1 = mem1[maddr1[7:0]];
  assign mrdata3 = mem3[maddr3[7:0]];

  always @(posedge clk) begin
    if (sw1) mem1[maddr1[7:0]] <= mwdata1;
    if (sw3) mem3[maddr3[7:0]] <= mwdata3;
  end

  lsu_align #(.ADDR_W(8), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_we(we), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wdata), .resp_valid(resp1), .resp_rdata(rdata1),
    .resp_err(err1), .mem_addr(maddr1), .mem_wdata(mwdata1), .mem_lw_en(lw1),
    .mem_sw_en(sw1), .mem_rdata(mrdata1)
  );

  lsu_align #(.ADDR_W(8), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rdy3), .req_we(we), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wdata), .resp_valid(resp3), .resp_rdata(rdata3),
    .resp_err(err3), .mem_addr(maddr3), .mem_wdata(mwdata3), .mem_lw_en(lw3),
    .mem_sw_en(sw3), .mem_rdata(mrdata3)
  );

  // Observation mux: whichever DUT the current request targets.
  logic o_rdy, o_resp, o_err, o_lw, o_sw;
  logic [31:0] o_rdata, o_maddr, o_mwdata;
  assign o_rdy    = use3 ? rdy3 : rdy1;
  assign o_resp   = use3 ? resp3 : resp1;
  assign o_err    = use3 ? err3 : err1;
  assign o_lw     = use3 ? lw3 : lw1;
  assign o_sw     = use3 ? sw3 : sw1;
  assign o_rdata  = use3 ? rdata3 : rdata1;
  assign o_maddr  = use3 ? maddr3 : maddr1;
  assign o_mwdata = use3 ? mwdata3 : mwdata1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge.
  task automatic run_req(input int idx, input vec_t v);
    int lat = 0;
    int lw = 0;
    int sw = 0;
    logic [31:0] rd = 32'hx;
    logic er = 1'bx;
    logic [31:0] wd = 32'd0;
    logic [31:0] ma = 32'd0;
    string tag;
    tag = $sformatf("vec%0d", idx);
    use3 = v.use3; we = v.we; f3 = v.f3; addr = v.addr; wdata = v.wdata; rv = 1'b1;
    #1 chk({tag, " ready"}, {31'd0, o_rdy}, 32'd1);
    @(negedge clk);
    rv = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (o_lw) begin lw++; ma = o_maddr; end
      if (o_sw) begin sw++; ma = o_maddr; wd = o_mwdata; end
      if (o_resp) begin lat = n; rd = o_rdata; er = o_err; break; end
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " rdata"}, rd, v.rdata);
    chk({tag, " err"}, {31'd0, er}, {31'd0, v.err});
    chk({tag, " lw_cycles"}, lw, v.lw);
    chk({tag, " sw_cycles"}, sw, v.sw);
    chk({tag, " mem_addr"}, ma, v.maddr);
    if (v.sw != 0) chk({tag, " mem_wdata"}, wd, v.mwdata);
    @(negedge clk);
    chk({tag, " resp_pulse"}, {31'd0, o_resp}, 32'd0);
  endtask

  initial begin
    int sw_seen;
    int rv_seen;
    int acc_cnt;
    int acc2_i;
    int resp_cnt;
    int resp1_i;
    int resp2_i;
    int overlap;
    logic [31:0] resp2_d;

    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'd0;
      mem3[i] = 32'd0;
    end
    mem1[5]   = 32'h8899AABB;
    mem1[255] = 32'h0BADF00D;
    mem3[5]   = 32'h8899AABB;

    //           use3 we  f3      addr         wdata          rdata          err lat lw sw mwdata          maddr
    vecs[0]  = '{0, 0, 3'b000, 32'h16, 32'h0, 32'hFFFFFF99, 0, 2, 1, 0, 32'h0, 32'd5};
    vecs[1]  = '{0, 0, 3'b101, 32'h14, 32'h0, 32'h0000AABB, 0, 2, 1, 0, 32'h0, 32'd5};
    vecs[2]  = '{0, 0, 3'b001, 32'h16, 32'h0, 32'hFFFF8899, 0, 2, 1, 0, 32'h0, 32'd5};
    vecs[3]  = '{0, 0, 3'b100, 32'h17, 32'h0, 32'h00000088, 0, 2, 1, 0, 32'h0, 32'd5};
    vecs[4]  = '{0, 0, 3'b010, 32'h14, 32'h0, 32'h8899AABB, 0, 2, 1, 0, 32'h0, 32'd5};
    vecs[5]  = '{0, 0, 3'b010, 32'h22, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 32'd0};
    vecs[6]  = '{0, 1, 3'b001, 32'h03, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 32'd0};
    vecs[7]  = '{0, 0, 3'b010, 32'h400, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 32'd0};
    vecs[8]  = '{0, 0, 3'b011, 32'h14, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 32'd0};
    vecs[9]  = '{0, 1, 3'b100, 32'h14, 32'h0, 32'h0, 1, 1, 0, 0, 32'h0, 32'd0};
    vecs[10] = '{0, 1, 3'b000, 32'h15, 32'h123456CD, 32'h0, 0, 3, 1, 1, 32'h8899CDBB, 32'd5};
    vecs[11] = '{0, 0, 3'b010, 32'h14, 32'h0, 32'h8899CDBB, 0, 2, 1, 0, 32'h0, 32'd5};
    vecs[12] = '{0, 1, 3'b001, 32'h16, 32'hFFFF1234, 32'h0, 0, 3, 1, 1, 32'h1234CDBB, 32'd5};
    vecs[13] = '{0, 0, 3'b001, 32'h16, 32'h0, 32'h00001234, 0, 2, 1, 0, 32'h0, 32'd5};
    vecs[14] = '{0, 1, 3'b010, 32'h08, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1, 32'hDEADBEEF, 32'd2};
    vecs[15] = '{0, 0, 3'b000, 32'h0B, 32'h0, 32'hFFFFFFDE, 0, 2, 1, 0, 32'h0, 32'd2};
    vecs[16] = '{0, 0, 3'b101, 32'h0A, 32'h0, 32'h0000DEAD, 0, 2, 1, 0, 32'h0, 32'd2};
    vecs[17] = '{0, 0, 3'b010, 32'h3FC, 32'h0, 32'h0BADF00D, 0, 2, 1, 0, 32'h0, 32'd255};
    vecs[18] = '{1, 0, 3'b010, 32'h14, 32'h0, 32'h8899AABB, 0, 4, 3, 0, 32'h0, 32'd5};
    vecs[19] = '{1, 1, 3'b000, 32'h15, 32'h123456CD, 32'h0, 0, 5, 3, 1, 32'h8899CDBB, 32'd5};
    vecs[20] = '{1, 0, 3'b100, 32'h15, 32'h0, 32'h000000CD, 0, 4, 3, 0, 32'h0, 32'd5};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst ready", {31'd0, rdy1}, 32'd0);
    chk("rst resp_valid", {31'd0, resp1}, 32'd0);
    chk("rst resp_err", {31'd0, err1}, 32'd0);
    chk("rst resp_rdata", rdata1, 32'd0);
    chk("rst enables", {30'd0, lw1, sw1}, 32'd0);
    chk("rst mem_addr", maddr1, 32'd0);
    chk("rst mem_wdata", mwdata1, 32'd0);
    rst = 1'b0;
    #1 chk("post-rst ready", {31'd0, rdy1}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 21; i++) run_req(i, vecs[i]);
    use3 = 1'b0;

    // Reset while an SB sits in RD: no write, no response, memory untouched.
    we = 1'b1; f3 = 3'b000; addr = 32'h15; wdata = 32'h000000AA; rv = 1'b1;
    @(negedge clk);
    rv = 1'b0;
    chk("rst_rd in_rd", {31'd0, lw1}, 32'd1);
    rst = 1'b1;
    #1 chk("rst_rd ready_low", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    chk("rst_rd lw_cleared", {31'd0, lw1}, 32'd0);
    rst = 1'b0;
    sw_seen = 0;
    rv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (sw1) sw_seen++;
      if (resp1) rv_seen++;
      @(negedge clk);
    end
    chk("rst_rd no_write", sw_seen, 0);
    chk("rst_rd no_resp", rv_seen, 0);
    chk("rst_rd mem_word", mem1[5], 32'h1234CDBB);
    chk("rst_rd ready_back", {31'd0, rdy1}, 32'd1);

    // Back-to-back SW then LW with req_valid held.
    we = 1'b1; f3 = 3'b010; addr = 32'h0; wdata = 32'hCAFEF00D; rv = 1'b1;
    acc_cnt = 0; acc2_i = -1; resp_cnt = 0; resp1_i = -1; resp2_i = -1; overlap = 0;
    resp2_d = 32'd0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (acc_cnt == 1) begin we = 1'b0; wdata = 32'd0; end
      if (acc_cnt == 2) rv = 1'b0;
      #1;
      if (resp1 && rdy1) overlap++;
      if (resp1) begin
        resp_cnt++;
        if (resp_cnt == 1) resp1_i = i;
        else begin resp2_i = i; resp2_d = rdata1; end
      end
      if (rv && rdy1) begin
        acc_cnt++;
        if (acc_cnt == 2) acc2_i = i;
      end
    end
    rv = 1'b0;
    chk("b2b accepts", acc_cnt, 2);
    chk("b2b sw_resp_cycle", resp1_i, 2);
    chk("b2b second_accept", acc2_i, 3);
    chk("b2b lw_resp_cycle", resp2_i, 5);
    chk("b2b lw_rdata", resp2_d, 32'hCAFEF00D);
    chk("b2b ready_in_resp", overlap, 0);
    chk("b2b mem_word", mem1[0], 32'hCAFEF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
